mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset; sampled only on clk rising edge.
REQ-003 SHALL have port start, input, 1, E-stage MDU instruction valid this cycle.
REQ-004 SHALL have port md_op, input, 3, operation code (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MSUB).
REQ-005 SHALL have port a, input, 32, operand rs.
REQ-006 SHALL have port b, input, 32, operand rt.
REQ-007 SHALL have port md_use, input, 1, D-stage instruction is any MDU op, including mfhi/mflo.
REQ-008 SHALL have port busy, output, 1, multi-cycle operation in progress.
REQ-009 SHALL have port stall, output, 1, request to freeze the D stage.
REQ-010 SHALL have port hi, output, 32, HI register.
REQ-011 SHALL have port lo, output, 32, LO register.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, with a 4-bit down-counter cnt.
REQ-013 SHALL go IDLE->MUL on start with mult/multu (and madd/msub when enabled), loading cnt=4.
REQ-014 SHALL go IDLE->DIV on start with div/divu, loading cnt=9.
REQ-015 SHALL decrement cnt each cycle in MUL/DIV, and SHALL write HI/LO and return to IDLE on the edge where cnt==0.
REQ-016 SHALL give mult a latency of 5 cycles: busy high for exactly 5 cycles after the start edge, with new HI/LO visible the cycle busy falls; div SHALL behave the same with 10 cycles.
REQ-017 SHALL latch a and b at the start edge; later operand changes SHALL have no effect.
REQ-018 SHALL compute mult as the signed 64-bit product and multu as the unsigned 64-bit product, with {hi,lo} = product.
REQ-019 SHALL compute div/divu as lo = quotient and hi = remainder; signed remainder SHALL take the sign of the dividend (truncating division).
REQ-020 SHALL leave HI/LO unchanged on divide by zero (b==0); busy timing SHALL be unchanged.
REQ-021 SHALL execute mthi/mtlo in a single cycle from IDLE: hi<=a or lo<=a on the start edge, with busy staying 0.
REQ-022 SHALL ignore start while busy; no state or HI/LO change.
REQ-023 SHALL drive stall = md_use & (busy | (start & multi-cycle op)).
REQ-024 SHALL allow start on the same edge busy falls, since the FSM is then in IDLE.
REQ-025 SHALL treat an undefined md_op with start as a no-op.

Reset
REQ-026 SHALL on reset==0 at a clk edge force state=IDLE, cnt=0, hi=0, lo=0, busy=0, and stall=0 (given md_use=0).
REQ-027 SHALL on reset mid-operation abort the operation, discard its result and leave HI/LO at 0.

Configuration
REQ-028 SHALL compile in MD_MADD/MD_MSUB when macro MDU_MADD_EN is defined: signed {hi,lo} += a*b or -= a*b, 64-bit wrap, 5-cycle latency using the HI/LO value at completion.
REQ-029 SHALL, without MDU_MADD_EN, treat MD_MADD/MD_MSUB as no-ops per REQ-025.

Structure
REQ-030 SHALL place the md_op encodings, FSM state encodings and latency constants (MUL_LAT=5, DIV_LAT=10) in a shared package used by the MDU controller and the instruction decoder.
REQ-031 SHALL isolate the 64-bit result computation (mul/div/madd arithmetic on the latched operands) in sub-module mdu_alu; mdu_ctrl owns the FSM, counter, HI/LO and stall.

Verification
REQ-032 SHALL cover: mult a=0xFFFFFFFF, b=2 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 SHALL cover: div a=-7, b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 -> HI/LO unchanged after 10 cycles.
REQ-034 SHALL cover: mthi a=0x12345678 while idle -> hi=0x12345678 next cycle with busy=0; a second start during mult -> ignored, and the mult result is correct.
REQ-035 SHALL cover: md_use=1 during a div -> stall high for all 10 busy cycles plus the start cycle; md_use=0 -> stall=0 throughout.
REQ-036 SHALL cover: reset low at cycle 3 of a mult -> next cycle busy=0, hi=lo=0, and no late write-back.
REQ-037 SHALL cover, with MDU_MADD_EN: hi=0, lo=5, madd a=3, b=4 -> lo=17, hi=0; without the macro -> HI/LO unchanged and busy=0.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: md_op encodings, controller states, latencies and
// op-class helpers. Build option: MDU_MADD_EN enables MD_MADD/MD_MSUB.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MSUB  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  // Ops that run through the multiplier path (MUL state).
  function automatic logic is_mul_op(input md_op_e op);
`ifdef MDU_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MSUB);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

  // Ops that run through the divider path (DIV state).
  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline-facing MDU bus: E-stage issue, D-stage hazard query, HI/LO view.
// Build option: MDU_MADD_EN (no effect on this interface).
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a, b, md_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, md_use,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mdu_alu.sv
// MDU arithmetic: 64-bit {hi,lo} result for mul/div (and madd/msub) on the
// latched operands. Build option: MDU_MADD_EN adds the accumulate input.
module mdu_alu
  import mdu_ctrl_pkg::*;
(
  input  md_op_e      i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
`ifdef MDU_MADD_EN
  input  logic [63:0] i_acc,
`endif
  output logic [63:0] o_result,
  output logic        o_wr
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic        [31:0] w_divisor;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic        [31:0] w_uquot;
  logic        [31:0] w_urem;

  assign w_sprod   = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod   = {32'd0, i_a} * {32'd0, i_b};
  // Divisor is forced nonzero so the dividers never see /0; o_wr masks it.
  assign w_divisor = (i_b == '0) ? 32'd1 : i_b;
  assign w_squot   = $signed(i_a) / $signed(w_divisor);
  assign w_srem    = $signed(i_a) % $signed(w_divisor);
  assign w_uquot   = i_a / w_divisor;
  assign w_urem    = i_a % w_divisor;

  // Select the result and whether it may be written to HI/LO.
  always_comb begin
    o_result = '0;
    o_wr     = 1'b0;
    case (i_op)
      MD_MULT: begin
        o_result = w_sprod;
        o_wr     = 1'b1;
      end
      MD_MULTU: begin
        o_result = w_uprod;
        o_wr     = 1'b1;
      end
      MD_DIV: begin
        o_result = {w_srem, w_squot};
        o_wr     = (i_b != '0);
      end
      MD_DIVU: begin
        o_result = {w_urem, w_uquot};
        o_wr     = (i_b != '0);
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        o_result = i_acc + w_sprod;
        o_wr     = 1'b1;
      end
      MD_MSUB: begin
        o_result = i_acc - w_sprod;
        o_wr     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: IDLE/MUL/DIV FSM with down-counter, HI/LO ownership and
// D-stage stall. Build option: MDU_MADD_EN enables MD_MADD/MD_MSUB.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  mdu_state_e  r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [31:0] r_a, r_b;
  md_op_e      r_op;
  md_op_e      w_op;
  logic        w_load;
  logic [63:0] w_result;
  logic        w_wr;
  logic        w_busy;

  assign w_op = md_op_e'(bus.md_op);

  mdu_alu u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
`ifdef MDU_MADD_EN
    .i_acc    ({r_hi, r_lo}),
`endif
    .o_result (w_result),
    .o_wr     (w_wr)
  );

  // State, counter, HI/LO and latched operands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= MD_MULT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      if (w_load) begin
        r_a  <= bus.a;
        r_b  <= bus.b;
        r_op <= w_op;
      end
    end
  end

  // Next-state: accept ops only in IDLE; write back on the cnt==0 edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (is_mul_op(w_op)) begin
            w_state_nxt = MUL;
            w_cnt_nxt   = 4'(MUL_LAT - 1);
            w_load      = 1'b1;
          end else if (is_div_op(w_op)) begin
            w_state_nxt = DIV;
            w_cnt_nxt   = 4'(DIV_LAT - 1);
            w_load      = 1'b1;
          end else if (w_op == MD_MTHI) begin
            w_hi_nxt = bus.a;
          end else if (w_op == MD_MTLO) begin
            w_lo_nxt = bus.a;
          end
        end
      end
      MUL, DIV: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          if (w_wr) begin
            w_hi_nxt = w_result[63:32];
            w_lo_nxt = w_result[31:0];
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy    = (r_state != IDLE);
  assign bus.busy  = w_busy;
  assign bus.stall = bus.md_use & (w_busy | (bus.start & (is_mul_op(w_op) | is_div_op(w_op))));
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized traffic
// against a cycle-level behavioural model. Honours MDU_MADD_EN.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  mdu_ctrl_if bus();

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi, m_lo;
  int          m_rem;
  logic        m_wr;
  logic [63:0] m_res;

  function automatic int latency(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 5;
      3'd2, 3'd3: return 10;
`ifdef MDU_MADD_EN
      3'd6, 3'd7: return 5;
`endif
      default:    return 0;
    endcase
  endfunction

  // Returns {write_enable, {hi,lo}} for a multi-cycle op.
  function automatic logic [64:0] calc(input logic [2:0] op, input logic [31:0] x,
                                       input logic [31:0] y, input logic [63:0] acc);
    longint p, q, r;
    p = longint'($signed(x)) * longint'($signed(y));
    case (op)
      3'd0: return {1'b1, 64'(p)};
      3'd1: return {1'b1, {32'd0, x} * {32'd0, y}};
      3'd2: begin
        if (y == 0) return {1'b0, 64'd0};
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        return {1'b1, 32'(r), 32'(q)};
      end
      3'd3: begin
        if (y == 0) return {1'b0, 64'd0};
        return {1'b1, x % y, x / y};
      end
      3'd6: return {1'b1, acc + 64'(p)};
      3'd7: return {1'b1, acc - 64'(p)};
      default: return {1'b0, 64'd0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_hi  <= '0;
      m_lo  <= '0;
      m_rem <= 0;
      m_wr  <= 1'b0;
      m_res <= '0;
    end else if (m_rem == 0) begin
      if (bus.start) begin
        if (bus.md_op == 3'd4) m_hi <= bus.a;
        else if (bus.md_op == 3'd5) m_lo <= bus.a;
        else if (latency(bus.md_op) > 0) begin
          m_rem <= latency(bus.md_op);
          {m_wr, m_res} <= calc(bus.md_op, bus.a, bus.b, {m_hi, m_lo});
        end
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_wr) {m_hi, m_lo} <= m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",  64'(bus.busy), 64'(m_rem > 0));
      check("hi",    64'(bus.hi), 64'(m_hi));
      check("lo",    64'(bus.lo), 64'(m_lo));
      check("stall", 64'(bus.stall),
            64'(bus.md_use & ((m_rem > 0) | (bus.start & (latency(bus.md_op) > 0)))));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = x;
    bus.b     = y;
    align();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Counts busy negedges; returns at the negedge where busy has fallen.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
  endtask

  int n, ns;
  logic [31:0] ra, rb;

  initial begin
    bus.start = 1'b0; bus.md_op = '0; bus.a = '0; bus.b = '0; bus.md_use = 1'b0;
    reset = 1'b0;
    align(); align();
    chk_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hi",   64'(bus.hi), 64'd0);
    check("rst_lo",   64'(bus.lo), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    align();

    issue(3'(MD_MULT), 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    check("mult_lat", 64'(n), 64'd5);
    check("mult_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);
    align();

    issue(3'(MD_MULTU), 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    check("multu_lat", 64'(n), 64'd5);
    check("multu_hi", 64'(bus.hi), 64'h1);
    check("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);
    align();

    issue(3'(MD_DIV), 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_lat", 64'(n), 64'd10);
    check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    align();

    issue(3'(MD_DIVU), 32'd7, 32'd0);
    count_busy(n);
    check("divz_lat", 64'(n), 64'd10);
    check("divz_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("divz_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    align();

    issue(3'(MD_MTHI), 32'h1234_5678, 32'd0);
    @(negedge clk);
    check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    align();

    // Second start two cycles into a mult must be ignored.
    issue(3'(MD_MULT), 32'd3, 32'd5);
    align();
    issue(3'(MD_DIV), 32'd100, 32'd7);
    count_busy(n);
    check("ign_lat", 64'(n), 64'd3);
    check("ign_hi", 64'(bus.hi), 64'd0);
    check("ign_lo", 64'(bus.lo), 64'd15);
    align();

    // Stall over a div with md_use held.
    bus.md_use = 1'b1;
    bus.start = 1'b1; bus.md_op = 3'(MD_DIV); bus.a = 32'd50; bus.b = 32'd3;
    @(negedge clk);
    ns = bus.stall ? 1 : 0;
    align();
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      if (bus.stall) ns++;
    end
    check("stall_cnt", 64'(ns), 64'd11);
    check("stall_end", 64'(bus.stall), 64'd0);
    check("div50_lo", 64'(bus.lo), 64'd16);
    check("div50_hi", 64'(bus.hi), 64'd2);
    align();
    bus.md_use = 1'b0;
    bus.start = 1'b1; bus.md_op = 3'(MD_DIV); bus.a = 32'd9; bus.b = 32'd4;
    @(negedge clk);
    ns = bus.stall ? 1 : 0;
    align();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.stall) ns++;
    end
    check("nostall_cnt", 64'(ns), 64'd0);
    align();

    // Reset during the third busy cycle of a mult.
    issue(3'(MD_MULT), 32'd7, 32'd9);
    align();
    align();
    reset = 1'b0;
    align();
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    for (int i = 0; i < 8; i++) align();
    @(negedge clk);
    check("abort_late_lo", 64'(bus.lo), 64'd0);
    align();

    issue(3'(MD_MTLO), 32'd5, 32'd0);
    issue(3'(MD_MADD), 32'd3, 32'd4);
    count_busy(n);
`ifdef MDU_MADD_EN
    check("madd_lat", 64'(n), 64'd5);
    check("madd_lo", 64'(bus.lo), 64'd17);
`else
    check("madd_lat", 64'(n), 64'd0);
    check("madd_lo", 64'(bus.lo), 64'd5);
`endif
    check("madd_hi", 64'(bus.hi), 64'd0);
    align();

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) != 0);
      bus.start  = ($urandom_range(0, 2) == 0);
      bus.md_op  = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : 32'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : 32'($urandom));
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      bus.a      = ra;
      bus.b      = rb;
      bus.md_use = 1'($urandom_range(0, 1));
      align();
    end
    reset = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) align();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
